// File: rtl/samx_pkg.sv
// rtl/samx_pkg.sv - shared types and slot constants for the SAMx4 DRAM sequencer
package samx_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        REF  = 2'd1,
        VID  = 2'd2,
        CPU  = 2'd3
    } owner_t;

    localparam logic [1:0] Z_CPU_ROW = 2'd0;
    localparam logic [1:0] Z_CPU_COL = 2'd1;
    localparam logic [1:0] Z_VID     = 2'd2;
    localparam logic [1:0] Z_REF     = 2'd3;

    localparam logic [2:0] P_RAS_ON = 3'd1;
    localparam logic [2:0] P_COL    = 3'd2;
    localparam logic [2:0] P_CAS_ON = 3'd3;
    localparam logic [2:0] P_ACK    = 3'd6;
    localparam logic [2:0] P_PRE    = 3'd7;

    // Video and refresh use a single Z source for both row and column.
    function automatic logic [1:0] z_code(input owner_t own, input logic col);
        case (own)
            CPU:     z_code = col ? Z_CPU_COL : Z_CPU_ROW;
            VID:     z_code = Z_VID;
            REF:     z_code = Z_REF;
            default: z_code = Z_CPU_ROW;
        endcase
    endfunction

endpackage

// File: rtl/dram_slot_if.sv
// rtl/dram_slot_if.sv - requester/strobe bundle between rate logic, sequencer and DRAM pins
interface dram_slot_if #(
    parameter int REF_ADDR_W = 7
);
    logic                  cpu_req;
    logic                  cpu_rnw;
    logic                  fast_mode;
    logic                  vid_req;
    logic                  nHS;
    logic                  nRAS0;
    logic                  nCAS;
    logic                  nWE;
    logic [1:0]            z_sel;
    logic [REF_ADDR_W-1:0] ref_addr;
    logic                  cpu_ack;
    logic                  vid_ack;
    logic [3:0]            phase;

    modport master (
        output cpu_req, cpu_rnw, fast_mode, vid_req, nHS,
        input  nRAS0, nCAS, nWE, z_sel, ref_addr, cpu_ack, vid_ack, phase
    );

    modport slave (
        input  cpu_req, cpu_rnw, fast_mode, vid_req, nHS,
        output nRAS0, nCAS, nWE, z_sel, ref_addr, cpu_ack, vid_ack, phase
    );
endinterface

// File: rtl/refresh_scheduler.sv
// rtl/refresh_scheduler.sv - nHS-credited refresh backlog and refresh row counter
module refresh_scheduler #(
    parameter int REFRESH_BURST = 8,
    parameter int REF_ADDR_W    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nHS,
    input  logic                  consume,
    output logic                  pend_nz,
    output logic [REF_ADDR_W-1:0] ref_addr
);

    localparam logic [5:0] BURST6 = 6'(REFRESH_BURST);

    // hs_q[1:0] is the synchronizer, hs_q[2] the previous synchronized level.
    logic [2:0] hs_q;
    logic [3:0] pend;
    logic [5:0] pend_sum;
    logic       credit;
    logic       take;

    assign credit  = hs_q[2] & ~hs_q[1];
    assign take    = consume & (pend != 4'd0);
    assign pend_nz = (pend != 4'd0);

    always_comb begin
        pend_sum = {2'b00, pend} + (credit ? BURST6 : 6'd0) - {5'd0, take};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q     <= 3'b111;
            pend     <= 4'd0;
            ref_addr <= '0;
        end else begin
            hs_q     <= {hs_q[1:0], nHS};
            pend     <= (pend_sum > 6'd15) ? 4'd15 : pend_sum[3:0];
            if (take)
                ref_addr <= ref_addr + 1'b1;
        end
    end

endmodule

// File: rtl/dram_slot_sequencer.sv
// rtl/dram_slot_sequencer.sv - 16-phase DRAM slot owner arbitration and strobe generation
module dram_slot_sequencer
    import samx_pkg::*;
#(
    parameter int REFRESH_BURST = 8,
    parameter int REF_ADDR_W    = 7
) (
    input  logic       OSCOut,
    input  logic       RES,
    dram_slot_if.slave bus
);

    logic [3:0]            t_q, t_nxt;
    owner_t                owner_q, owner_nxt;
    logic                  rnw_q, rnw_nxt;
    logic [2:0]            p_nxt;
    logic                  pend_nz;
    logic                  consume;
    logic [REF_ADDR_W-1:0] ref_addr;

    logic       nras_q, ncas_q, nwe_q, cack_q, vack_q;
    logic [1:0] z_q;
    logic       nras_d, ncas_d, nwe_d, cack_d, vack_d;
    logic [1:0] z_d;

    assign consume = (owner_q == REF) && (t_q[2:0] == P_PRE);

    refresh_scheduler #(
        .REFRESH_BURST(REFRESH_BURST),
        .REF_ADDR_W   (REF_ADDR_W)
    ) u_refresh (
        .clk     (OSCOut),
        .rst     (RES),
        .nHS     (bus.nHS),
        .consume (consume),
        .pend_nz (pend_nz),
        .ref_addr(ref_addr)
    );

    always_ff @(posedge OSCOut or posedge RES) begin
        if (RES) begin
            t_q     <= 4'd0;
            owner_q <= NONE;
            rnw_q   <= 1'b1;
        end else begin
            t_q     <= t_nxt;
            owner_q <= owner_nxt;
            rnw_q   <= rnw_nxt;
        end
    end

    // Owner is decided during p0 and held through p7 of the slot.
    always_comb begin
        t_nxt     = t_q + 4'd1;
        owner_nxt = owner_q;
        rnw_nxt   = rnw_q;
        if (t_q[2:0] == 3'd0) begin
            rnw_nxt = bus.cpu_rnw;
            if (!t_q[3]) begin
                if (pend_nz)                         owner_nxt = REF;
                else if (bus.vid_req)                owner_nxt = VID;
                else if (bus.fast_mode && bus.cpu_req) owner_nxt = CPU;
                else                                 owner_nxt = NONE;
            end else begin
                if (bus.cpu_req)  owner_nxt = CPU;
                else if (pend_nz) owner_nxt = REF;
                else              owner_nxt = NONE;
            end
        end
    end

    // Decode against the upcoming phase so every pin comes straight from a flop.
    assign p_nxt = t_nxt[2:0];

    always_comb begin
        nras_d = 1'b1;
        ncas_d = 1'b1;
        nwe_d  = 1'b1;
        z_d    = Z_CPU_ROW;
        cack_d = 1'b0;
        vack_d = 1'b0;
        if (owner_nxt != NONE && p_nxt != 3'd0) begin
            nras_d = !(p_nxt >= P_RAS_ON && p_nxt < P_PRE);
            if (p_nxt >= P_CAS_ON && p_nxt < P_PRE) begin
                ncas_d = (owner_nxt == REF);
                nwe_d  = !(owner_nxt == CPU && !rnw_nxt);
            end
            z_d    = z_code(owner_nxt, p_nxt >= P_COL);
            cack_d = (owner_nxt == CPU) && (p_nxt == P_ACK);
            vack_d = (owner_nxt == VID) && (p_nxt == P_ACK);
        end
    end

    always_ff @(posedge OSCOut or posedge RES) begin
        if (RES) begin
            nras_q <= 1'b1;
            ncas_q <= 1'b1;
            nwe_q  <= 1'b1;
            z_q    <= Z_CPU_ROW;
            cack_q <= 1'b0;
            vack_q <= 1'b0;
        end else begin
            nras_q <= nras_d;
            ncas_q <= ncas_d;
            nwe_q  <= nwe_d;
            z_q    <= z_d;
            cack_q <= cack_d;
            vack_q <= vack_d;
        end
    end

    assign bus.nRAS0    = nras_q;
    assign bus.nCAS     = ncas_q;
    assign bus.nWE      = nwe_q;
    assign bus.z_sel    = z_q;
    assign bus.cpu_ack  = cack_q;
    assign bus.vid_ack  = vack_q;
    assign bus.phase    = t_q;
    assign bus.ref_addr = ref_addr;

endmodule
